// File: rtl/pinball_scorer.sv
// Pinball scorer: serialises hole pulses into awards with a combo multiplier,
// keeps a saturating score and the ball count, and raises game_over.
module pinball_scorer #(
   parameter int BALLS       = 8,
   parameter int COMBO_TICKS = 50_000_000,
   parameter int MAX_SCORE   = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic [7:0]  getball,
   output logic [13:0] score,
   output logic [3:0]  ball_left,
   output logic [2:0]  mult,
   output logic        award_valid,
   output logic [2:0]  award_hole,
   output logic [8:0]  award_pts,
   output logic        game_over
);

   localparam int TW = $clog2(COMBO_TICKS + 1);
   localparam logic [TW-1:0] TICKS = TW'(COMBO_TICKS);
   localparam logic [14:0] MAXV = 15'(MAX_SCORE);
   localparam logic [3:0] BALLS_V = 4'(BALLS);
   localparam logic [2:0] ST_RESET = 3'd0;
   localparam logic [2:0] ST_GET = 3'd3;

   logic [13:0]   r_score;
   logic [3:0]    r_ball_left;
   logic [2:0]    r_mult;
   logic          r_award_valid;
   logic [2:0]    r_award_hole;
   logic [8:0]    r_award_pts;
   logic          r_game_over;
   logic [7:0]    r_pending;
   logic [TW-1:0] r_timer;

   logic          w_clear;
   logic          w_accept;
   logic [7:0]    w_cand;
   logic [7:0]    w_grant;
   logic          w_award;
   logic [2:0]    w_hole;
   logic [2:0]    w_mult_n;
   logic [6:0]    w_base;
   logic [8:0]    w_pts;
   logic [14:0]   w_sum;
   logic [13:0]   w_score_n;
   logic [3:0]    w_bl_n;

   always_comb begin
      w_clear  = rst || (state == ST_RESET);
      w_accept = (state == ST_GET) && !r_game_over;
      w_cand   = w_accept ? (r_pending | getball) : 8'd0;
      w_grant  = w_cand & (~w_cand + 8'd1);
      w_award  = |w_cand;
      w_hole   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_grant[i]) w_hole = 3'(i);
      end
      // Any award inside the window chains the combo, capped at x4
      if (r_timer != '0)
         w_mult_n = (r_mult >= 3'd4) ? 3'd4 : r_mult + 3'd1;
      else
         w_mult_n = 3'd1;
      w_base    = 7'd10 * (7'(w_hole) + 7'd1);
      w_pts     = 9'(w_base) * 9'(w_mult_n);
      w_sum     = 15'(r_score) + 15'(w_pts);
      w_score_n = (w_sum > MAXV) ? MAXV[13:0] : w_sum[13:0];
      w_bl_n    = r_ball_left - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_score       <= 14'd0;
         r_ball_left   <= BALLS_V;
         r_mult        <= 3'd1;
         r_award_valid <= 1'b0;
         r_award_hole  <= 3'd0;
         r_award_pts   <= 9'd0;
         r_game_over   <= 1'b0;
         r_pending     <= 8'd0;
         r_timer       <= '0;
      end else if (w_award) begin
         r_pending     <= (w_bl_n == 4'd0) ? 8'd0 : (w_cand & ~w_grant);
         r_score       <= w_score_n;
         r_ball_left   <= w_bl_n;
         r_mult        <= w_mult_n;
         r_timer       <= TICKS;
         r_award_valid <= 1'b1;
         r_award_hole  <= w_hole;
         r_award_pts   <= w_pts;
         r_game_over   <= (w_bl_n == 4'd0);
      end else begin
         r_award_valid <= 1'b0;
         if (r_game_over) r_pending <= 8'd0;
         if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
            // Multiplier stays frozen after game over
            if (r_timer == TW'(1) && !r_game_over) r_mult <= 3'd1;
         end
      end
   end

   assign score       = r_score;
   assign ball_left   = r_ball_left;
   assign mult        = r_mult;
   assign award_valid = r_award_valid;
   assign award_hole  = r_award_hole;
   assign award_pts   = r_award_pts;
   assign game_over   = r_game_over;

endmodule

// File: tb/tb_pinball_scorer.sv
// Scoreboard bench for pinball_scorer: a cycle model pushes expected
// outputs per drive, and they are popped and compared after each edge.
module tb_pinball_scorer;

   typedef struct {
      int inst;
      int score;
      int bl;
      int mult;
      int av;
      int ah;
      int ap;
      int go;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  st0 = 3'd0, st1 = 3'd0;
   logic [7:0]  gb0 = 8'd0, gb1 = 8'd0;
   logic [13:0] sc0, sc1;
   logic [3:0]  bl0, bl1;
   logic [2:0]  mu0, mu1;
   logic        av0, av1;
   logic [2:0]  ah0, ah1;
   logic [8:0]  ap0, ap1;
   logic        go0, go1;

   int n_checks = 0;
   int n_errors = 0;
   exp_t q[$];

   int balls[2] = '{8, 15};
   int maxs[2] = '{9999, 1000};
   int ms[2], mbl[2], mm[2], mav[2], mah[2], map_[2], mgo[2], mpend[2], mt[2];

   always #5 clk = ~clk;

   pinball_scorer #(.BALLS(8), .COMBO_TICKS(100), .MAX_SCORE(9999)) u_main (
      .clk(clk), .rst(rst), .state(st0), .getball(gb0),
      .score(sc0), .ball_left(bl0), .mult(mu0), .award_valid(av0),
      .award_hole(ah0), .award_pts(ap0), .game_over(go0)
   );

   pinball_scorer #(.BALLS(15), .COMBO_TICKS(100), .MAX_SCORE(1000)) u_sat (
      .clk(clk), .rst(rst), .state(st1), .getball(gb1),
      .score(sc1), .ball_left(bl1), .mult(mu1), .award_valid(av1),
      .award_hole(ah1), .award_pts(ap1), .game_over(go1)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic mstep(input int k, input bit r, input int st, input int g);
      int cand;
      int h;
      int mn;
      int pts;
      bit aw;
      if (r || st == 0) begin
         ms[k] = 0; mbl[k] = balls[k]; mm[k] = 1;
         mav[k] = 0; mah[k] = 0; map_[k] = 0;
         mgo[k] = 0; mpend[k] = 0; mt[k] = 0;
         return;
      end
      aw = 1'b0;
      if (st == 3 && mgo[k] == 0) begin
         cand = mpend[k] | g;
         if (cand != 0) begin
            h = 0;
            while (((cand >> h) & 1) == 0) h++;
            mpend[k] = cand & ~(1 << h);
            mn = (mt[k] != 0) ? ((mm[k] + 1 > 4) ? 4 : mm[k] + 1) : 1;
            pts = 10 * (h + 1) * mn;
            ms[k] = (ms[k] + pts > maxs[k]) ? maxs[k] : ms[k] + pts;
            mbl[k]--;
            mm[k] = mn;
            mt[k] = 100;
            mav[k] = 1; mah[k] = h; map_[k] = pts;
            if (mbl[k] == 0) begin
               mgo[k] = 1;
               mpend[k] = 0;
            end
            aw = 1'b1;
         end
      end
      if (!aw) begin
         mav[k] = 0;
         if (mt[k] > 0) begin
            if (mt[k] == 1 && mgo[k] == 0) mm[k] = 1;
            mt[k]--;
         end
      end
   endtask

   task automatic push(input int k);
      exp_t e;
      e.inst = k; e.score = ms[k]; e.bl = mbl[k]; e.mult = mm[k];
      e.av = mav[k]; e.ah = mah[k]; e.ap = map_[k]; e.go = mgo[k];
      q.push_back(e);
   endtask

   task automatic compare_one();
      exp_t e;
      string p;
      if (q.size() == 0) begin
         check("queue_empty", 0, 1);
         return;
      end
      e = q.pop_front();
      if (e.inst == 0) begin
         p = "main";
         check({p, ".score"}, int'(sc0), e.score);
         check({p, ".ball_left"}, int'(bl0), e.bl);
         check({p, ".mult"}, int'(mu0), e.mult);
         check({p, ".award_valid"}, int'(av0), e.av);
         check({p, ".award_hole"}, int'(ah0), e.ah);
         check({p, ".award_pts"}, int'(ap0), e.ap);
         check({p, ".game_over"}, int'(go0), e.go);
      end else begin
         p = "sat";
         check({p, ".score"}, int'(sc1), e.score);
         check({p, ".ball_left"}, int'(bl1), e.bl);
         check({p, ".mult"}, int'(mu1), e.mult);
         check({p, ".award_valid"}, int'(av1), e.av);
         check({p, ".award_hole"}, int'(ah1), e.ah);
         check({p, ".award_pts"}, int'(ap1), e.ap);
         check({p, ".game_over"}, int'(go1), e.go);
      end
   endtask

   // sel picks which DUT receives st/g; the other sits in WAIT
   task automatic step(input bit r, input int st, input logic [7:0] g,
                       input int sel);
      rst = r;
      st0 = (sel == 0) ? 3'(st) : 3'd1;
      gb0 = (sel == 0) ? g : 8'd0;
      st1 = (sel == 1) ? 3'(st) : 3'd1;
      gb1 = (sel == 1) ? g : 8'd0;
      mstep(0, r, int'(st0), int'(gb0));
      mstep(1, r, int'(st1), int'(gb1));
      push(0);
      push(1);
      @(posedge clk);
      #1;
      compare_one();
      compare_one();
   endtask

   task automatic idle(input int n, input int st, input int sel);
      for (int i = 0; i < n; i++) step(1'b0, st, 8'd0, sel);
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(1'b1, 0, 8'd0, 0);
      step(1'b1, 0, 8'd0, 0);
      idle(3, 3, 0);
      // single entry on hole 2
      step(1'b0, 3, 8'h04, 0);
      idle(3, 3, 0);
      // combo on hole 0, then let the window expire
      step(1'b0, 3, 8'h01, 0);
      idle(9, 3, 0);
      step(1'b0, 3, 8'h01, 0);
      idle(105, 3, 0);
      // state RESET clears, then simultaneous pulses
      step(1'b0, 0, 8'd0, 0);
      step(1'b0, 3, 8'h81, 0);
      idle(4, 3, 0);
      // gated states ignore pulses
      step(1'b0, 1, 8'hff, 0);
      step(1'b0, 2, 8'h3c, 0);
      step(1'b0, 4, 8'h10, 0);
      idle(3, 3, 0);
      // merge: hole 2 pulses again while pending
      step(1'b0, 0, 8'd0, 0);
      step(1'b0, 3, 8'h06, 0);
      step(1'b0, 3, 8'h04, 0);
      idle(3, 3, 0);
      // rst with pending 06
      step(1'b0, 0, 8'd0, 0);
      step(1'b0, 3, 8'h07, 0);
      step(1'b1, 3, 8'd0, 0);
      idle(4, 3, 0);
      // eight awards to game over, then blocked pulses
      for (int i = 0; i < 8; i++) step(1'b0, 3, 8'(1 << i), 0);
      step(1'b0, 3, 8'h10, 0);
      step(1'b0, 3, 8'hff, 0);
      idle(3, 3, 0);
      step(1'b0, 4, 8'd0, 0);
      step(1'b0, 0, 8'd0, 0);
      idle(2, 3, 0);
      // game over with pulses still queued
      step(1'b0, 0, 8'd0, 0);
      for (int i = 0; i < 7; i++) step(1'b0, 3, 8'h01, 0);
      step(1'b0, 3, 8'he0, 0);
      idle(4, 3, 0);
      idle(110, 4, 0);
      // saturation on the second instance
      step(1'b1, 0, 8'd0, 1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 3, 8'h80, 1);
         step(1'b0, 3, 8'd0, 1);
      end
      idle(3, 3, 1);
      if (q.size() != 0) check("queue_drain", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
